// File: rtl/hll_pkg.sv
// Shared types for the HyperLogLog DMA read path: scheduler states and the
// DMA read-command packing.
package hll_pkg;

  localparam int BEAT_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } hll_sched_state_t;

  typedef struct packed {
    logic [31:0] length;
    logic [63:0] address;
  } dma_cmd_t;

endpackage

// File: rtl/hll_chunk_calc.sv
// Next command length: smallest of the bytes left in the job, the per-command cap,
// and the room before the next page boundary.
module hll_chunk_calc #(
  parameter int MAX_CHUNK_BYTES = 1024,
  parameter int PAGE_BYTES      = 4096,
  parameter int PW              = $clog2(PAGE_BYTES)
) (
  input  logic [PW-1:0] cur_off_i,
  input  logic [31:0]   remaining_i,
  output logic [32:0]   chunk_o
);

  logic [32:0] page_room;
  logic [32:0] rem_ext;
  logic [32:0] max_ext;

  always_comb begin
    page_room = 33'(PAGE_BYTES) - 33'(cur_off_i);
    rem_ext   = {1'b0, remaining_i};
    max_ext   = 33'(MAX_CHUNK_BYTES);
    chunk_o   = rem_ext;
    if (max_ext < chunk_o) chunk_o = max_ext;
    if (page_room < chunk_o) chunk_o = page_room;
  end

endmodule

// File: rtl/hll_dma_read_scheduler.sv
// Splits one host-memory read job into page-safe DMA read commands, throttled by
// a credit count of issued-but-unreceived bytes; pulses done once all data is back.
module hll_dma_read_scheduler
  import hll_pkg::*;
#(
  parameter int MAX_CHUNK_BYTES = 1024,
  parameter int PAGE_BYTES      = 4096,
  parameter int MAX_OUTST_BYTES = 8192
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        s_job_valid,
  output logic        s_job_ready,
  input  logic [63:0] s_job_addr,
  input  logic [31:0] s_job_len,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [63:0] m_cmd_address,
  output logic [31:0] m_cmd_length,
  input  logic        s_beat,
  output logic        busy,
  output logic        done,
  output logic [31:0] cmd_count,
  output logic [31:0] beat_count,
  output logic        err_spurious
);

  localparam int          PW        = $clog2(PAGE_BYTES);
  localparam logic [32:0] MaxOutst  = 33'(MAX_OUTST_BYTES);
  localparam logic [32:0] BeatBytes = 33'(BEAT_BYTES);

  hll_sched_state_t state_q, state_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [32:0] outst_q, outst_d;
  logic        cmd_valid_q, cmd_valid_d;
  dma_cmd_t    cmd_q, cmd_d;
  logic [31:0] cmd_count_q, cmd_count_d;
  logic [31:0] beat_count_q, beat_count_d;
  logic        err_q, err_d;
  logic [32:0] chunk;
  logic        cmd_hs;

  hll_chunk_calc #(
    .MAX_CHUNK_BYTES(MAX_CHUNK_BYTES),
    .PAGE_BYTES     (PAGE_BYTES),
    .PW             (PW)
  ) u_chunk (
    .cur_off_i  (cur_addr_q[PW-1:0]),
    .remaining_i(remaining_q),
    .chunk_o    (chunk)
  );

  assign cmd_hs        = cmd_valid_q && m_cmd_ready;
  assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign s_job_ready   = (state_q == IDLE);
  assign m_cmd_valid   = cmd_valid_q;
  assign m_cmd_address = cmd_q.address;
  assign m_cmd_length  = cmd_q.length;
  assign cmd_count     = cmd_count_q;
  assign beat_count    = beat_count_q;
  assign err_spurious  = err_q;

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through this block infers a latch.
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    outst_d      = outst_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_d        = cmd_q;
    cmd_count_d  = cmd_count_q;
    beat_count_d = beat_count_q;
    err_d        = err_q;

    // A beat with no credit outstanding is data we never asked for.
    if (s_beat) begin
      if (outst_q == '0) begin
        err_d = 1'b1;
      end else begin
        outst_d = outst_q - BeatBytes;
        if (busy) beat_count_d = beat_count_q + 32'd1;
      end
    end
    if (cmd_hs) outst_d = outst_d + {1'b0, cmd_q.length};

    unique case (state_q)
      IDLE: begin
        if (s_job_valid) begin
          cur_addr_d   = s_job_addr;
          remaining_d  = s_job_len;
          cmd_count_d  = '0;
          beat_count_d = '0;
          state_d      = (s_job_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_hs) begin
          cur_addr_d  = cur_addr_q + 64'(cmd_q.length);
          remaining_d = remaining_q - cmd_q.length;
          cmd_count_d = cmd_count_q + 32'd1;
          cmd_valid_d = 1'b0;
          if (remaining_d == '0) state_d = DRAIN;
        end else if (!cmd_valid_q && (outst_q + chunk) <= MaxOutst) begin
          cmd_valid_d   = 1'b1;
          cmd_d.address = cur_addr_q;
          cmd_d.length  = chunk[31:0];
        end
      end
      DRAIN: begin
        if (outst_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    // NOTE: sequential state uses non-blocking assignment only, so every register samples pre-edge values.
    if (user_rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      outst_q      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= '0;
      cmd_count_q  <= '0;
      beat_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      outst_q      <= outst_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      cmd_count_q  <= cmd_count_d;
      beat_count_q <= beat_count_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_hll_dma_read_scheduler.sv
// Bench for hll_dma_read_scheduler: a job-level model (command list, byte credits,
// done timing) checked every cycle, plus directed jobs with literal expectations.
module tb_hll_dma_read_scheduler;

  localparam longint MAX_OUTST = 8192;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic        s_job_valid = 1'b0;
  logic        s_job_ready;
  logic [63:0] s_job_addr = '0;
  logic [31:0] s_job_len = '0;
  logic        m_cmd_valid;
  logic        m_cmd_ready = 1'b1;
  logic [63:0] m_cmd_address;
  logic [31:0] m_cmd_length;
  logic        s_beat = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] cmd_count;
  logic [31:0] beat_count;
  logic        err_spurious;

  hll_dma_read_scheduler dut (
    .user_clk     (user_clk),
    .user_rst     (user_rst),
    .s_job_valid  (s_job_valid),
    .s_job_ready  (s_job_ready),
    .s_job_addr   (s_job_addr),
    .s_job_len    (s_job_len),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_ready  (m_cmd_ready),
    .m_cmd_address(m_cmd_address),
    .m_cmd_length (m_cmd_length),
    .s_beat       (s_beat),
    .busy         (busy),
    .done         (done),
    .cmd_count    (cmd_count),
    .beat_count   (beat_count),
    .err_spurious (err_spurious)
  );

  always #5 user_clk = ~user_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
  } cmd_t;

  cmd_t   exp_q[$];
  cmd_t   obs_q[$];
  longint mout = 0;
  bit     exp_busy, exp_done, exp_ready, exp_err, live;
  int     exp_cmds, exp_beats;
  bit     was_busy, ready_now, fin;

  int issued = 0, sent = 0, manual_left = 0;
  bit auto_beat = 1'b0, beat_from_manual = 1'b0;

  // Expected command list straight from the splitting rule.
  task automatic build_cmds(input logic [63:0] a0, input logic [31:0] len);
    logic [63:0] a = a0;
    longint unsigned rem = len;
    longint unsigned room, c;
    cmd_t t;
    exp_q.delete();
    while (rem > 0) begin
      room = 4096 - longint'(a[11:0]);
      c = rem;
      if (c > 1024) c = 1024;
      if (c > room) c = room;
      t.addr = a;
      t.len  = 32'(c);
      exp_q.push_back(t);
      a   = a + 64'(c);
      rem = rem - c;
    end
  endtask

  always @(negedge user_clk) begin
    if (live) begin
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      check("job_ready", 64'(s_job_ready), 64'(exp_ready));
      check("err_spurious", 64'(err_spurious), 64'(exp_err));
      check("cmd_count", 64'(cmd_count), 64'(exp_cmds));
      check("beat_count", 64'(beat_count), 64'(exp_beats));
      if (m_cmd_valid) begin
        if (exp_q.size() == 0 || !exp_busy) begin
          check("cmd_valid_unexpected", 64'(m_cmd_valid), 64'd0);
        end else begin
          check("cmd_address", m_cmd_address, exp_q[0].addr);
          check("cmd_length", 64'(m_cmd_length), 64'(exp_q[0].len));
          check("outst_cap", 64'(mout + longint'(m_cmd_length) <= MAX_OUTST), 64'd1);
        end
      end
    end
    // Apply the events the coming rising edge will see.
    if (user_rst) begin
      exp_q.delete();
      mout = 0; exp_busy = 0; exp_done = 0; exp_ready = 1; exp_err = 0;
      exp_cmds = 0; exp_beats = 0; live = 1;
    end else if (live) begin
      was_busy  = exp_busy;
      ready_now = exp_ready;
      fin       = exp_busy && exp_q.size() == 0 && mout == 0;
      if (exp_done) begin exp_done = 0; exp_ready = 1; end
      if (fin) begin exp_busy = 0; exp_done = 1; end
      if (s_beat) begin
        if (mout == 0) exp_err = 1;
        else begin
          mout -= 64;
          if (was_busy) exp_beats++;
        end
      end
      if (m_cmd_valid && m_cmd_ready && exp_q.size() > 0) begin
        cmd_t o;
        o.addr = m_cmd_address;
        o.len  = m_cmd_length;
        obs_q.push_back(o);
        mout   += longint'(exp_q[0].len);
        issued += int'(exp_q[0].len >> 6);
        exp_q.pop_front();
        exp_cmds++;
      end
      if (ready_now && s_job_valid) begin
        exp_ready = 0;
        build_cmds(s_job_addr, s_job_len);
        exp_cmds = 0; exp_beats = 0;
        if (s_job_len == 0) exp_done = 1;
        else exp_busy = 1;
      end
    end
  end

  // Beat source: returns one beat per cycle for every issued beat, plus manual pulses.
  always @(posedge user_clk) begin
    if (s_beat) begin
      if (beat_from_manual) manual_left--;
      else sent++;
    end
    #1;
    if (manual_left > 0) begin
      s_beat = 1'b1; beat_from_manual = 1'b1;
    end else if (auto_beat && issued > sent) begin
      s_beat = 1'b1; beat_from_manual = 1'b0;
    end else begin
      s_beat = 1'b0; beat_from_manual = 1'b0;
    end
  end

  task automatic submit(input logic [63:0] a, input logic [31:0] l);
    int k = 0;
    @(negedge user_clk);
    while (!s_job_ready && k < 200) begin @(negedge user_clk); k++; end
    check("submit_ready_seen", 64'(s_job_ready), 64'd1);
    @(posedge user_clk); #1;
    s_job_valid = 1'b1; s_job_addr = a; s_job_len = l;
    @(posedge user_clk); #1;
    s_job_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    @(negedge user_clk);
    while (!done && k < budget) begin @(negedge user_clk); k++; end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic check_obs(input int idx, input logic [63:0] a, input logic [31:0] l, input string name);
    if (obs_q.size() > idx) begin
      check({name, "_addr"}, obs_q[idx].addr, a);
      check({name, "_len"}, 64'(obs_q[idx].len), 64'(l));
    end else begin
      check({name, "_missing"}, 64'(obs_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge user_clk);
    #1 user_rst = 1'b0;

    @(negedge user_clk);
    check("rst_job_ready", 64'(s_job_ready), 64'd1);
    check("rst_cmd_valid", 64'(m_cmd_valid), 64'd0);
    check("rst_cmd_address", m_cmd_address, 64'd0);
    check("rst_cmd_length", 64'(m_cmd_length), 64'd0);
    check("rst_busy_done", 64'({busy, done, err_spurious}), 64'd0);

    // Empty job: straight to the done pulse.
    submit(64'h40, 32'd0);
    @(negedge user_clk);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_ready", 64'(s_job_ready), 64'd0);
    @(negedge user_clk);
    check("len0_done_clear", 64'(done), 64'd0);
    check("len0_ready_back", 64'(s_job_ready), 64'd1);

    // Aligned 4 KiB job with prompt data return.
    auto_beat = 1'b1;
    obs_q.delete();
    submit(64'h1000, 32'd4096);
    wait_done(400, "job1_done");
    check("job1_cmd_count", 64'(cmd_count), 64'd4);
    check("job1_beat_count", 64'(beat_count), 64'd64);
    for (int i = 0; i < 4; i++) check_obs(i, 64'h1000 + 64'(i) * 64'h400, 32'd1024, "job1_cmd");

    // Page split.
    obs_q.delete();
    submit(64'hF80, 32'd256);
    wait_done(200, "job2_done");
    check_obs(0, 64'hF80, 32'd128, "job2_cmd0");
    check_obs(1, 64'h1000, 32'd128, "job2_cmd1");
    check("job2_beat_count", 64'(beat_count), 64'd4);

    // Command held under backpressure.
    m_cmd_ready = 1'b0;
    submit(64'h2000, 32'd2048);
    k = 0;
    @(negedge user_clk);
    while (!m_cmd_valid && k < 50) begin @(negedge user_clk); k++; end
    check("stall_valid_seen", 64'(m_cmd_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge user_clk);
      check("stall_valid", 64'(m_cmd_valid), 64'd1);
      check("stall_addr", m_cmd_address, 64'h2000);
      check("stall_len", 64'(m_cmd_length), 64'd1024);
    end
    @(posedge user_clk); #1 m_cmd_ready = 1'b1;
    wait_done(200, "stall_done");
    check("stall_cmd_count", 64'(cmd_count), 64'd2);

    // Spurious beat in IDLE, then a job that wraps the 64-bit address space.
    @(negedge user_clk);
    manual_left = 1;
    repeat (3) @(negedge user_clk);
    check("spurious_err", 64'(err_spurious), 64'd1);
    obs_q.delete();
    submit(64'hFFFF_FFFF_FFFF_FFC0, 32'd128);
    wait_done(200, "wrap_done");
    check_obs(0, 64'hFFFF_FFFF_FFFF_FFC0, 32'd64, "wrap_cmd0");
    check_obs(1, 64'h0, 32'd64, "wrap_cmd1");
    check("err_sticky", 64'(err_spurious), 64'd1);

    // Credit limit with no data returned, then partial release.
    auto_beat = 1'b0;
    submit(64'h10000, 32'd16384);
    k = 0;
    @(negedge user_clk);
    while (cmd_count != 32'd8 && k < 200) begin @(negedge user_clk); k++; end
    check("credit_8_cmds", 64'(cmd_count), 64'd8);
    repeat (20) @(negedge user_clk);
    check("credit_still_8", 64'(cmd_count), 64'd8);
    check("credit_blocked", 64'(m_cmd_valid), 64'd0);
    manual_left = 16;
    repeat (40) @(negedge user_clk);
    check("credit_release_9", 64'(cmd_count), 64'd9);
    check("credit_blocked_again", 64'(m_cmd_valid), 64'd0);
    check("credit_beats", 64'(beat_count), 64'd16);

    // Reset in the middle of the job.
    @(posedge user_clk); #1 user_rst = 1'b1;
    @(posedge user_clk); #1 user_rst = 1'b0;
    @(negedge user_clk);
    check("midrst_cmd_valid", 64'(m_cmd_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(s_job_ready), 64'd1);
    check("midrst_counts", 64'({cmd_count, beat_count}), 64'd0);
    check("midrst_err", 64'(err_spurious), 64'd0);

    repeat (2) @(negedge user_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
